// File: rtl/nic_pe_if.sv
// CPU-to-router network interface: one-packet input and output mailboxes between a CPU register port and a router PE port.
// Optional build macro NIC_WR_ERR_EN adds a sticky error flag for rejected output-buffer writes.
module nic_pe_if (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        net_so,
  output logic [63:0] net_do,
  input  logic        net_ro,
  input  logic        net_si,
  input  logic [63:0] net_di,
  output logic        net_ri,
  input  logic        net_polarity
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  buf_state_t  in_state_reg;
  buf_state_t  out_state_reg;
  logic [63:0] in_buf_reg;
  logic [63:0] out_buf_reg;
  logic        in_full;
  logic        out_full;
  logic        err;

  logic cpu_rd;
  logic cpu_wr;
  logic rd_in_buf;
  logic rd_out_status;
  logic wr_out_buf;
  logic wr_accept;
  logic wr_reject;

  assign in_full  = (in_state_reg  == FULL);
  assign out_full = (out_state_reg == FULL);

  assign cpu_rd        = nicEn & ~nicWrEn;
  assign cpu_wr        = nicEn & nicWrEn;
  assign rd_in_buf     = cpu_rd & (addr == ADDR_IN_BUF);
  assign rd_out_status = cpu_rd & (addr == ADDR_OUT_STATUS);
  assign wr_out_buf    = cpu_wr & (addr == ADDR_OUT_BUF);
  // A write that lands while the buffer is still full (including the send edge) is refused.
  assign wr_accept     = wr_out_buf & ~out_full;
  assign wr_reject     = wr_out_buf & out_full;

  assign net_ri = ~in_full;
  // VC bit must match the router's current polarity phase before the packet may leave.
  assign net_so = out_full & net_ro & (net_polarity == out_buf_reg[63]);
  assign net_do = out_buf_reg;

  always_comb begin
    d_out = 64'd0;
    if (cpu_rd) begin
      case (addr)
        ADDR_IN_BUF:     d_out = in_buf_reg;
        ADDR_IN_STATUS:  d_out = {63'd0, in_full};
        ADDR_OUT_BUF:    d_out = out_buf_reg;
        ADDR_OUT_STATUS: d_out = {62'd0, err, out_full};
        default:         d_out = 64'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_state_reg  <= EMPTY;
      out_state_reg <= EMPTY;
      in_buf_reg    <= 64'd0;
      out_buf_reg   <= 64'd0;
    end else begin
      case (in_state_reg)
        EMPTY: begin
          if (net_si) begin
            in_buf_reg   <= net_di;
            in_state_reg <= FULL;
          end
        end
        FULL: begin
          if (rd_in_buf) in_state_reg <= EMPTY;
        end
        default: in_state_reg <= EMPTY;
      endcase

      case (out_state_reg)
        EMPTY: begin
          if (wr_accept) begin
            out_buf_reg   <= d_in;
            out_state_reg <= FULL;
          end
        end
        FULL: begin
          if (net_so) out_state_reg <= EMPTY;
        end
        default: out_state_reg <= EMPTY;
      endcase
    end
  end

`ifdef NIC_WR_ERR_EN
  logic err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (wr_reject) begin
      err_reg <= 1'b1;
    end else if (rd_out_status) begin
      err_reg <= 1'b0;
    end
  end

  assign err = err_reg;
`else
  logic unused_err_inputs;

  assign err               = 1'b0;
  assign unused_err_inputs = wr_reject | rd_out_status;
`endif

endmodule

// File: tb/tb_nic_pe_if.sv
// Directed self-checking bench for nic_pe_if: CPU mailbox access, router handshake, polarity gating and reset.
// Expected err-flag values follow the NIC_WR_ERR_EN build macro.
module tb_nic_pe_if;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ro;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ri;
  logic        net_polarity;

  int vec_count;
  int err_count;

  localparam logic [63:0] PKT_A = 64'h6020_0003_3333_3333;
  localparam logic [63:0] PKT_V = 64'hE020_0003_3333_3333;
  localparam logic [63:0] PKT_I = 64'h4020_0202_AAAA_AAAA;
  localparam logic [63:0] PKT_J = 64'h4020_0202_5555_5555;
  localparam logic [63:0] PKT_B = 64'h1234_5678_9ABC_DEF0;

`ifdef NIC_WR_ERR_EN
  localparam logic [63:0] ERR_BIT = 64'd2;
`else
  localparam logic [63:0] ERR_BIT = 64'd0;
`endif

  nic_pe_if dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_do       (net_do),
    .net_ro       (net_ro),
    .net_si       (net_si),
    .net_di       (net_di),
    .net_ri       (net_ri),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cpu();
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
    addr    = 2'b00;
  endtask

  // Combinational CPU read of one register, checked before the next edge.
  task automatic cpu_read(input logic [1:0] a, input string tag, input logic [63:0] exp);
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    addr    = a;
    #1;
    check(tag, d_out, exp);
    tick();
    idle_cpu();
  endtask

  task automatic cpu_write_out(input logic [63:0] data);
    nicEn   = 1'b1;
    nicWrEn = 1'b1;
    addr    = 2'b10;
    d_in    = data;
    tick();
    idle_cpu();
  endtask

  initial begin
    vec_count    = 0;
    err_count    = 0;
    reset        = 1'b0;
    idle_cpu();
    d_in         = 64'd0;
    net_ro       = 1'b0;
    net_si       = 1'b0;
    net_di       = 64'd0;
    net_polarity = 1'b0;

    // Reset state
    #12;
    check("rst_net_ri", {63'd0, net_ri}, 64'd1);
    check("rst_net_so", {63'd0, net_so}, 64'd0);
    check("rst_d_out", d_out, 64'd0);
    check("rst_net_do", net_do, 64'd0);
    reset = 1'b1;
    tick();

    // Idle status reads
    cpu_read(2'b01, "idle_in_status", 64'd0);
    cpu_read(2'b11, "idle_out_status", 64'd0);
    check("idle_net_ri", {63'd0, net_ri}, 64'd1);

    // Basic send, VC 0, polarity 0
    net_ro = 1'b1;
    net_polarity = 1'b0;
    #1;
    check("snd_so_before", {63'd0, net_so}, 64'd0);
    cpu_write_out(PKT_A);
    #1;
    check("snd_so", {63'd0, net_so}, 64'd1);
    check("snd_do", net_do, PKT_A);
    tick();
    check("snd_so_after", {63'd0, net_so}, 64'd0);
    cpu_read(2'b11, "snd_status_after", 64'd0);

    // Polarity gating with VC 1
    cpu_write_out(PKT_V);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("pol_wait_%0d", i), {63'd0, net_so}, 64'd0);
      tick();
    end
    net_polarity = 1'b1;
    #1;
    check("pol_so", {63'd0, net_so}, 64'd1);
    net_ro = 1'b0;
    #1;
    check("pol_ro_block", {63'd0, net_so}, 64'd0);
    cpu_read(2'b11, "pol_still_full", 64'd1);
    net_ro = 1'b1;
    #1;
    check("pol_so_ro", {63'd0, net_so}, 64'd1);
    check("pol_do", net_do, PKT_V);
    tick();
    cpu_read(2'b11, "pol_sent_status", 64'd0);
    net_polarity = 1'b0;

    // Input path
    net_si = 1'b1;
    net_di = PKT_I;
    #1;
    check("in_ri_before", {63'd0, net_ri}, 64'd1);
    tick();
    net_si = 1'b0;
    #1;
    check("in_ri_full", {63'd0, net_ri}, 64'd0);
    cpu_read(2'b01, "in_status_full", 64'd1);
    net_si = 1'b1;
    net_di = PKT_J;
    tick();
    net_si = 1'b0;
    cpu_read(2'b00, "in_buf_read", PKT_I);
    #1;
    check("in_ri_after_read", {63'd0, net_ri}, 64'd1);
    cpu_read(2'b01, "in_status_empty", 64'd0);

    // Back-to-back writes with router not ready
    net_ro = 1'b0;
    cpu_write_out(PKT_A);
    cpu_write_out(PKT_B);
    check("b2b_do_kept", net_do, PKT_A);
    cpu_read(2'b11, "b2b_status_err", ERR_BIT | 64'd1);
    cpu_read(2'b11, "b2b_status_clr", 64'd1);
    cpu_read(2'b10, "b2b_out_buf", PKT_A);
    net_ro = 1'b1;
    #1;
    check("b2b_so", {63'd0, net_so}, 64'd1);

    // Write in the same cycle as the send is refused
    cpu_write_out(PKT_B);
    #1;
    check("sim_so_after", {63'd0, net_so}, 64'd0);
    check("sim_do_old", net_do, PKT_A);
    cpu_read(2'b11, "sim_status", ERR_BIT);
    cpu_read(2'b11, "sim_status_clr", 64'd0);

    // Reset while both buffers are full
    net_ro = 1'b0;
    net_si = 1'b1;
    net_di = PKT_I;
    cpu_write_out(PKT_B);
    net_si = 1'b0;
    #1;
    check("rst2_ri_full", {63'd0, net_ri}, 64'd0);
    net_ro = 1'b1;
    net_polarity = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("rst2_ri", {63'd0, net_ri}, 64'd1);
    check("rst2_so", {63'd0, net_so}, 64'd0);
    check("rst2_do", net_do, 64'd0);
    check("rst2_d_out", d_out, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    #1;
    check("rst2_so_rel", {63'd0, net_so}, 64'd0);
    cpu_read(2'b11, "rst2_out_status", 64'd0);
    cpu_read(2'b01, "rst2_in_status", 64'd0);
    cpu_read(2'b10, "rst2_out_buf", 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/nic_pe_if.md
NIC_PE_IF -- requirements
Module: nic_pe_if

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port addr, input, 2 bits: CPU register select (00 in-buf, 01 in-status, 10 out-buf, 11 out-status).
REQ-004 SHALL have port d_in, input, 64 bits: CPU write data.
REQ-005 SHALL have port d_out, output, 64 bits: CPU read data.
REQ-006 SHALL have port nicEn, input, 1 bit: CPU access enable.
REQ-007 SHALL have port nicWrEn, input, 1 bit: 1 = write, 0 = read (valid only with nicEn=1).
REQ-008 SHALL have port net_so, output, 1 bit: send strobe to the router PE input (pesi).
REQ-009 SHALL have port net_do, output, 64 bits: packet to the router PE input (pedi).
REQ-010 SHALL have port net_ro, input, 1 bit: router PE-input ready (peri).
REQ-011 SHALL have port net_si, input, 1 bit: send strobe from the router PE output (peso).
REQ-012 SHALL have port net_di, input, 64 bits: packet from the router PE output (pedo).
REQ-013 SHALL have port net_ri, output, 1 bit: ready to the router PE output (pero).
REQ-014 SHALL have port net_polarity, input, 1 bit: router polarity (even/odd cycle).

Function
REQ-015 Packet format SHALL be: [63] VC, [62:61] dir, [60:56] reserved, [55:52] hop_x, [51:48] hop_y, [47:40] src_x, [39:32] src_y, [31:0] payload; the block SHALL pass all 64 bits unmodified.
REQ-016 Block SHALL hold one 64-bit input buffer with flag in_full and one 64-bit output buffer with flag out_full.
REQ-017 net_ri SHALL equal ~in_full (combinational).
REQ-018 On an edge with net_si=1 and in_full=0, in_buf SHALL load net_di and in_full SHALL become 1; net_si while in_full=1 SHALL be ignored.
REQ-019 CPU read (nicEn=1, nicWrEn=0) SHALL drive d_out combinationally: addr 00 -> in_buf; 01 -> {63'b0,in_full}; 10 -> out_buf; 11 -> {62'b0,err,out_full}; d_out SHALL be 0 when nicEn=0 or nicWrEn=1.
REQ-020 Read of addr 00 SHALL clear in_full at the same edge; net_ri therefore rises the following cycle.
REQ-021 CPU write to addr 10 with out_full=0 SHALL load d_in into out_buf and set out_full at that edge; writes to addr 00/01/11 SHALL have no effect.
REQ-022 Write to addr 10 with out_full=1 SHALL leave out_buf unchanged.
REQ-023 net_so SHALL equal out_full & net_ro & (net_polarity == out_buf[63]) (combinational); net_do SHALL equal out_buf at all times.
REQ-024 On an edge with net_so=1, out_full SHALL clear; minimum write-to-send latency is one cycle; one packet per out_full period, never duplicated.
REQ-025 Write to addr 10 in the same cycle as net_so=1 SHALL be rejected (buffer still full at that edge).
REQ-026 Output path SHALL be a two-state FSM EMPTY/FULL (out_full): EMPTY->FULL on accepted write; FULL->EMPTY on send; input path likewise EMPTY/FULL on net_si accept / addr-00 read.

Reset
REQ-027 While reset=0, in_full, out_full, err SHALL be 0 and in_buf, out_buf SHALL be 0, asynchronously.
REQ-028 Reset mid-transfer SHALL discard buffered packets; after deassertion net_ri=1, net_so=0, d_out=0 with nicEn=0.

Configuration
REQ-029 Macro NIC_WR_ERR_EN: when defined, a rejected write (REQ-022/025) SHALL set sticky err, read at d_out[1] of addr 11 and cleared by that read; when undefined, err SHALL be constant 0 and rejected writes silently dropped.

Verification
REQ-030 Reset then idle -> net_ri=1, net_so=0, status reads 01/11 return 0.
REQ-031 Write addr10 d_in=64'h6020_0003_3333_3333, net_ro=1, net_polarity=0 -> net_so=1 next cycle with net_do=that value; status 11 reads 0 after.
REQ-032 Same packet with VC bit=1, net_polarity held 0 for 3 cycles then 1 -> net_so only after polarity=1; net_ro=0 blocks send.
REQ-033 net_si=1, net_di=64'h4020_0202_AAAA_AAAA -> net_ri=0, status 01 reads 1, addr 00 reads packet, next cycle net_ri=1; second net_si while full ignored.
REQ-034 Two back-to-back writes to addr10 with net_ro=0 -> second dropped, out_buf keeps first; with NIC_WR_ERR_EN addr 11 reads 3 then 1.
REQ-035 Reset asserted while out_full=1 and in_full=1 -> both flags 0 immediately, no send after release.
